// File: rtl/dma_host_programmer.sv
// Host-side sequencer: programs an 8237A-style DMA through IOW writes, then grants the bus on HRQ until EOP.
// Optional build macro DMA_HOST_MEM2MEM_EN adds the two destination-address writes.
module dma_host_programmer #(
    parameter int unsigned HLDA_DELAY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  channel,
    input  logic [7:0]  cmd_in,
    input  logic [7:0]  mode_in,
    input  logic [15:0] src_addr,
    input  logic [15:0] dst_addr,
    input  logic [15:0] count,
    input  logic        HRQ,
    input  logic        EOP,
    output logic        IOW,
    output logic [3:0]  address_A_in,
    output logic [7:0]  DMA_data_bus_in,
    output logic        HLDA,
    output logic        busy,
    output logic        done
);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned WR_W  = 12;
`ifdef DMA_HOST_MEM2MEM_EN
    localparam int unsigned NUM_WR = 10;
`else
    localparam int unsigned NUM_WR = 8;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_STROBE, S_HOLD_WAIT, S_GRANT, S_RELEASE
    } state_e;

    typedef struct packed {
        logic [1:0]  ch;
        logic [7:0]  cmd;
        logic [5:0]  mode_hi;
        logic [15:0] src;
`ifdef DMA_HOST_MEM2MEM_EN
        logic [15:0] dst;
`endif
        logic [15:0] cnt;
    } desc_t;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    desc_t            desc_q, desc_d;
    logic             accept_c;
    logic [WR_W-1:0]  wr_c;
    logic             iow_d, hlda_d, busy_d, done_d;
    logic [3:0]       addr_d;
    logic [7:0]       data_d;
    logic             iow_q, hlda_q, busy_q, done_q;
    logic [3:0]       addr_q;
    logic [7:0]       data_q;

`ifdef DMA_HOST_MEM2MEM_EN
    logic unused_mode_lo;
    assign unused_mode_lo = ^mode_in[1:0];
`else
    logic unused_inputs;
    assign unused_inputs = ^{dst_addr, mode_in[1:0]};
`endif

    // {address, data} of write k of the programming sequence
    function automatic logic [WR_W-1:0] wr_entry(input logic [IDX_W-1:0] k, input desc_t d);
        logic [3:0]      base_a;
        logic [WR_W-1:0] e;
        base_a = {1'b0, d.ch, 1'b0};
        e      = '0;
        case (k)
            IDX_W'(0): e = {4'd12, 8'h00};
            IDX_W'(1): e = {4'd8, d.cmd};
            IDX_W'(2): e = {4'd11, d.mode_hi, d.ch};
            IDX_W'(3): e = {base_a, d.src[7:0]};
            IDX_W'(4): e = {base_a, d.src[15:8]};
            IDX_W'(5): e = {base_a | 4'd1, d.cnt[7:0]};
            IDX_W'(6): e = {base_a | 4'd1, d.cnt[15:8]};
`ifdef DMA_HOST_MEM2MEM_EN
            IDX_W'(7): e = {4'd2, d.dst[7:0]};
            IDX_W'(8): e = {4'd2, d.dst[15:8]};
            IDX_W'(9): e = {4'd10, 6'b0, d.ch};
`else
            IDX_W'(7): e = {4'd10, 6'b0, d.ch};
`endif
            default:   e = '0;
        endcase
        return e;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        hold_cnt_d = hold_cnt_q;
        accept_c   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept_c   = 1'b1;
                    idx_d      = '0;
                    hold_cnt_d = '0;
                    state_d    = S_SETUP;
                end
            end
            S_SETUP:  state_d = S_STROBE;
            S_STROBE: begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = (idx_q == IDX_W'(NUM_WR - 1)) ? S_HOLD_WAIT : S_SETUP;
            end
            // grant once HRQ has been seen high for HLDA_DELAY consecutive cycles
            S_HOLD_WAIT: begin
                if (!HRQ) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q + CNT_W'(1) == CNT_W'(HLDA_DELAY)) begin
                    hold_cnt_d = '0;
                    state_d    = S_GRANT;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            S_GRANT:   if (EOP || !HRQ) state_d = S_RELEASE;
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        iow_d  = 1'b0;
        addr_d = '0;
        data_d = '0;
        hlda_d = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        wr_c   = wr_entry(idx_q, desc_q);
        unique case (state_q)
            S_SETUP: begin
                {addr_d, data_d} = wr_c;
                busy_d           = 1'b1;
            end
            S_STROBE: begin
                {addr_d, data_d} = wr_c;
                iow_d            = 1'b1;
                busy_d           = 1'b1;
            end
            S_HOLD_WAIT: busy_d = 1'b1;
            S_GRANT: begin
                hlda_d = 1'b1;
                busy_d = 1'b1;
            end
            S_RELEASE: done_d = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        desc_d         = '0;
        desc_d.ch      = channel;
        desc_d.cmd     = cmd_in;
        desc_d.mode_hi = mode_in[7:2];
        desc_d.src     = src_addr;
`ifdef DMA_HOST_MEM2MEM_EN
        desc_d.dst     = dst_addr;
`endif
        desc_d.cnt     = count;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            desc_q <= '0;
        end else if (accept_c) begin
            desc_q <= desc_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            iow_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            hlda_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            iow_q  <= iow_d;
            addr_q <= addr_d;
            data_q <= data_d;
            hlda_q <= hlda_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign IOW             = iow_q;
    assign address_A_in    = addr_q;
    assign DMA_data_bus_in = data_q;
    assign HLDA            = hlda_q;
    assign busy            = busy_q;
    assign done            = done_q;
endmodule

// File: tb/tb_dma_host_programmer.sv
// Bench for dma_host_programmer: directed handshake scenarios plus randomized descriptors
// compared cycle by cycle against a behavioural model of the write list and the hold/release rules.
module tb_dma_host_programmer;
    localparam int unsigned HLDA_D = 2;
`ifdef DMA_HOST_MEM2MEM_EN
    localparam int NW = 10;
`else
    localparam int NW = 8;
`endif
    localparam int H     = 2 * NW + 1;
    localparam int EDGES = 256;

    logic        clk = 1'b0;
    logic        reset, start, HRQ, EOP;
    logic [1:0]  channel;
    logic [7:0]  cmd_in, mode_in;
    logic [15:0] src_addr, dst_addr, count;
    logic        IOW, HLDA, busy, done;
    logic [3:0]  address_A_in;
    logic [7:0]  DMA_data_bus_in;

    int          checks = 0;
    int          errors = 0;
    int          cyc;
    logic [11:0] exp_q[$];
    bit          hrq_a [EDGES];
    bit          eop_a [EDGES];
    bit          st_a  [EDGES];

    dma_host_programmer #(.HLDA_DELAY(HLDA_D)) dut (
        .clk(clk), .reset(reset), .start(start), .channel(channel),
        .cmd_in(cmd_in), .mode_in(mode_in), .src_addr(src_addr), .dst_addr(dst_addr),
        .count(count), .HRQ(HRQ), .EOP(EOP), .IOW(IOW), .address_A_in(address_A_in),
        .DMA_data_bus_in(DMA_data_bus_in), .HLDA(HLDA), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] obs();
        return {IOW, address_A_in, DMA_data_bus_in, HLDA, busy, done};
    endfunction

    // cyc = index of the last rising edge; outputs are read on the following falling edge
    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic set_desc(input logic [1:0] ch, input logic [7:0] cmd, input logic [7:0] mode,
                            input logic [15:0] src, input logic [15:0] dst, input logic [15:0] cnt);
        channel  = ch;
        cmd_in   = cmd;
        mode_in  = mode;
        src_addr = src;
        dst_addr = dst;
        count    = cnt;
    endtask

    task automatic rand_desc(input logic [1:0] ch);
        set_desc(ch, 8'($urandom), 8'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    endtask

    // expected (address, data) list from the descriptor currently on the inputs
    function automatic void build_exp();
        logic [3:0] a;
        a = 4'(2 * int'(channel));
        exp_q.delete();
        exp_q.push_back({4'd12, 8'h00});
        exp_q.push_back({4'd8, cmd_in});
        exp_q.push_back({4'd11, mode_in[7:2], channel});
        exp_q.push_back({a, src_addr[7:0]});
        exp_q.push_back({a, src_addr[15:8]});
        exp_q.push_back({4'(a + 4'd1), count[7:0]});
        exp_q.push_back({4'(a + 4'd1), count[15:8]});
`ifdef DMA_HOST_MEM2MEM_EN
        exp_q.push_back({4'd2, dst_addr[7:0]});
        exp_q.push_back({4'd2, dst_addr[15:8]});
`endif
        exp_q.push_back({4'd10, 6'b0, channel});
    endfunction

    // e: edge whose HRQ sample completes HLDA_D consecutive highs in HOLD_WAIT; g: first later edge with EOP or !HRQ
    function automatic void model_grant(output int e, output int g);
        int run;
        run = 0;
        e   = -1;
        g   = -1;
        for (int ed = H; ed < EDGES && e < 0; ed++) begin
            run = hrq_a[ed] ? run + 1 : 0;
            if (run == int'(HLDA_D)) e = ed;
        end
        for (int ed = e + 1; e >= 0 && ed < EDGES && g < 0; ed++)
            if (eop_a[ed] || !hrq_a[ed]) g = ed;
        if (e < 0 || g < 0) begin
            e = EDGES - 6;
            g = EDGES - 5;
        end
    endfunction

    function automatic logic [15:0] model_out(input int c, input int e, input int g);
        logic [11:0] w;
        logic        iow;
        w   = '0;
        iow = 1'b0;
        if (c >= 1 && c <= 2 * NW) begin
            w   = exp_q[(c - 1) / 2];
            iow = (c % 2 == 0);
        end
        return {iow, w, (c > e && c <= g), (c >= 1 && c <= g), (c == g + 1)};
    endfunction

    task automatic clear_stim();
        for (int i = 0; i < EDGES; i++) begin
            hrq_a[i] = 1'b0;
            eop_a[i] = 1'b0;
            st_a[i]  = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        HRQ   = 1'b0;
        EOP   = 1'b0;
        set_desc(2'd0, 8'h00, 8'h00, 16'h0, 16'h0, 16'h0);
        repeat (2) @(negedge clk);
        checks++;
        if (obs() !== 16'h0) begin
            errors++;
            $display("FAIL reset_state got=%h exp=%h", obs(), 16'h0);
        end
        reset = 1'b1;
        cyc   = 0;
        step();
        checks++;
        if (obs() !== 16'h0) begin
            errors++;
            $display("FAIL reset_release got=%h exp=%h", obs(), 16'h0);
        end
    endtask

    // literal write list and handshake timing for the reference descriptor
    task automatic test_basic();
        logic [11:0] lit [NW];
        logic [15:0] exp_v;
`ifdef DMA_HOST_MEM2MEM_EN
        lit = '{12'hC00, 12'h800, 12'hB48, 12'h034, 12'h012, 12'h110, 12'h100, 12'h2EF, 12'h2BE, 12'hA00};
        set_desc(2'd0, 8'h00, 8'h48, 16'h1234, 16'hBEEF, 16'h0010);
`else
        lit = '{12'hC00, 12'h800, 12'hB4A, 12'h434, 12'h412, 12'h510, 12'h500, 12'hA02};
        set_desc(2'd2, 8'h00, 8'h48, 16'h1234, 16'h0000, 16'h0010);
`endif
        start = 1'b1;
        cyc   = -1;
        step();
        start = 1'b0;
        while (cyc < H + 16) begin
            HRQ = (cyc + 1 >= H + 3) && (cyc + 1 <= H + 14);
            EOP = (cyc + 1 == H + 13);
            step();
            exp_v = '0;
            if (cyc <= 2 * NW) begin
                exp_v[14:3] = lit[(cyc - 1) / 2];
                exp_v[15]   = (cyc % 2 == 0);
            end
            exp_v[2] = (cyc >= H + 3 + int'(HLDA_D)) && (cyc <= H + 13);
            exp_v[1] = (cyc <= H + 13);
            exp_v[0] = (cyc == H + 14);
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL basic cyc=%0d got=%h exp=%h", cyc, obs(), exp_v);
            end
        end
        HRQ = 1'b0;
        EOP = 1'b0;
    endtask

    // HRQ pulse, gap, then steady: grant counts from the second rise; EOP and HRQ drop together
    task automatic test_glitch();
        int          e, g;
        logic [15:0] exp_v;
        clear_stim();
        rand_desc(2'($urandom));
        build_exp();
        st_a[0]  = 1'b1;
        hrq_a[H] = 1'b1;
        for (int i = H + 2; i <= H + 6; i++) hrq_a[i] = 1'b1;
        eop_a[H + 7] = 1'b1;
        model_grant(e, g);
        cyc = -1;
        for (int ed = 0; ed <= g + 3; ed++) begin
            start = st_a[ed];
            HRQ   = hrq_a[ed];
            EOP   = eop_a[ed];
            step();
            exp_v = model_out(cyc, e, g);
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL glitch cyc=%0d got=%h exp=%h", cyc, obs(), exp_v);
            end
        end
        start = 1'b0;
        HRQ   = 1'b0;
        EOP   = 1'b0;
    endtask

    // extra starts while busy, HRQ high on entry, EOP during HOLD_WAIT
    task automatic test_busy_ignore();
        int          e, g;
        logic [15:0] exp_v;
        clear_stim();
        set_desc(2'd2, 8'h00, 8'h48, 16'h1234, 16'h5678, 16'h0010);
        build_exp();
        st_a[0]     = 1'b1;
        st_a[5]     = 1'b1;
        st_a[H + 4] = 1'b1;
        for (int i = H - 3; i <= H + 6; i++) hrq_a[i] = 1'b1;
        eop_a[H]     = 1'b1;
        eop_a[H + 1] = 1'b1;
        model_grant(e, g);
        cyc = -1;
        for (int ed = 0; ed <= g + 6; ed++) begin
            start = st_a[ed];
            HRQ   = hrq_a[ed];
            EOP   = eop_a[ed];
            if (ed > 0 && st_a[ed]) rand_desc(2'd3);
            step();
            exp_v = model_out(cyc, e, g);
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL busy_ignore cyc=%0d got=%h exp=%h", cyc, obs(), exp_v);
            end
        end
        start = 1'b0;
        HRQ   = 1'b0;
        EOP   = 1'b0;
    endtask

    task automatic test_reset_mid();
        int          e, g;
        logic [15:0] exp_v;
        rand_desc(2'($urandom));
        build_exp();
        start = 1'b1;
        cyc   = -1;
        step();
        start = 1'b0;
        while (cyc < 6) step();
        reset = 1'b0;
        #1;
        checks++;
        if (obs() !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid_abort got=%h exp=%h", obs(), 16'h0);
        end
        @(negedge clk);
        reset = 1'b1;
        HRQ   = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            checks++;
            if (obs() !== 16'h0) begin
                errors++;
                $display("FAIL reset_mid_quiet step=%0d got=%h exp=%h", i, obs(), 16'h0);
            end
        end
        HRQ = 1'b0;
        clear_stim();
        st_a[0] = 1'b1;
        for (int i = H; i <= H + 3; i++) hrq_a[i] = 1'b1;
        model_grant(e, g);
        cyc = -1;
        for (int ed = 0; ed <= g + 3; ed++) begin
            start = st_a[ed];
            HRQ   = hrq_a[ed];
            EOP   = eop_a[ed];
            step();
            exp_v = model_out(cyc, e, g);
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL reset_fresh cyc=%0d got=%h exp=%h", cyc, obs(), exp_v);
            end
        end
        start = 1'b0;
        HRQ   = 1'b0;
    endtask

    task automatic test_random();
        int          e, g;
        logic [15:0] exp_v;
        for (int t = 0; t < 25; t++) begin
            clear_stim();
            rand_desc(2'($urandom));
            build_exp();
            for (int i = 0; i < EDGES; i++) begin
                hrq_a[i] = ($urandom_range(0, 3) != 0);
                eop_a[i] = ($urandom_range(0, 7) == 0);
            end
            for (int i = 150; i < EDGES; i++) begin
                hrq_a[i] = (i < 180);
                eop_a[i] = 1'b0;
            end
            model_grant(e, g);
            st_a[0] = 1'b1;
            for (int i = 1; i <= g; i++) st_a[i] = ($urandom_range(0, 5) == 0);
            cyc = -1;
            for (int ed = 0; ed <= g + 3; ed++) begin
                start = st_a[ed];
                HRQ   = hrq_a[ed];
                EOP   = eop_a[ed];
                if (ed > 0 && st_a[ed]) rand_desc(2'($urandom));
                step();
                exp_v = model_out(cyc, e, g);
                checks++;
                if (obs() !== exp_v) begin
                    errors++;
                    $display("FAIL random t=%0d cyc=%0d got=%h exp=%h", t, cyc, obs(), exp_v);
                end
            end
            start = 1'b0;
            HRQ   = 1'b0;
            EOP   = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
